// File: rtl/udma_cfg_pkg.sv
// Shared types and constants for the uDMA cfg-bus APB master.
// Optional REQ watchdog is enabled with the UDMA_CFG_TIMEOUT_EN macro.
package udma_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } cfg_state_e;

  localparam int          UDMA_CFG_REG_AW      = 5;
  localparam int          UDMA_CFG_PERIPH_SPAN = 128;
  localparam logic [31:0] UDMA_CFG_ERR_DATA    = 32'h0;

endpackage

// File: rtl/udma_apb_cfg_master_if.sv
// APB bus bundle between the SoC APB and the uDMA cfg-bus master.
interface udma_apb_cfg_master_if #(
  parameter int APB_AWIDTH = 12
);
  logic [APB_AWIDTH-1:0] paddr;
  logic [31:0]           pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/udma_cfg_wdt.sv
// REQ-state watchdog: counts REQ cycles without ready, flags expiry on the
// cycle that would complete LIMIT waiting cycles. Used under UDMA_CFG_TIMEOUT_EN.
module udma_cfg_wdt #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [W-1:0] cnt_q;

  // count waiting cycles, restart whenever the FSM is outside REQ
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= cnt_q + 1'b1;
  end

  // cnt_q holds the number of earlier waiting cycles, so this is the LIMIT-th
  assign expired = en && (cnt_q == W'(LIMIT - 1));
endmodule

// File: rtl/udma_apb_cfg_master.sv
// APB slave to uDMA cfg-bus initiator. One outstanding access; the selected
// target sees exactly one valid+ready cycle per access.
// Optional REQ watchdog: define UDMA_CFG_TIMEOUT_EN.
module udma_apb_cfg_master
  import udma_cfg_pkg::*;
#(
  parameter int N_PERIPHS      = 4,
  parameter int PER_ID_W       = 2,
  parameter int APB_AWIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  udma_apb_cfg_master_if.slave     apb,
  output logic [31:0]              cfg_data_o,
  output logic [UDMA_CFG_REG_AW-1:0] cfg_addr_o,
  output logic                     cfg_rwn_o,
  output logic [N_PERIPHS-1:0]     cfg_valid_o,
  input  logic [32*N_PERIPHS-1:0]  cfg_data_i,
  input  logic [N_PERIPHS-1:0]     cfg_ready_i
);
  localparam int                ID_LSB = $clog2(UDMA_CFG_PERIPH_SPAN);
  localparam logic [PER_ID_W:0] N_LIM  = N_PERIPHS[PER_ID_W:0];

  cfg_state_e state_q, state_d;

  logic [UDMA_CFG_REG_AW-1:0] addr_q;
  logic [PER_ID_W-1:0]        id_q;
  logic [31:0]                wdata_q;
  logic [31:0]                rdata_q;
  logic                       rwn_q;
  logic                       err_q;

  logic [APB_AWIDTH-1:0] paddr;
  logic [PER_ID_W-1:0]   paddr_id;
  logic                  setup;
  logic                  id_ok;
  logic                  ready_sel;
  logic [31:0]           lane_rdata;
  logic                  wdt_expired;

  assign paddr    = apb.paddr;
  assign paddr_id = paddr[ID_LSB +: PER_ID_W];
  assign setup    = apb.psel && !apb.penable;
  assign id_ok    = ({1'b0, paddr_id} < N_LIM);

  // ready and read data of the currently addressed lane
  always_comb begin
    ready_sel  = 1'b0;
    lane_rdata = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      if (id_q == PER_ID_W'(k)) begin
        ready_sel  = cfg_ready_i[k];
        lane_rdata = cfg_data_i[32*k +: 32];
      end
    end
  end

`ifdef UDMA_CFG_TIMEOUT_EN
  udma_cfg_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr     (state_q != ST_REQ),
    .en      ((state_q == ST_REQ) && !ready_sel),
    .expired (wdt_expired)
  );
`else
  assign wdt_expired = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic; APB inputs only matter in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (setup) state_d = id_ok ? ST_REQ : ST_RESP;
      ST_REQ:  if (ready_sel || wdt_expired) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // access latches: request fields at setup, response at ready or expiry
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q  <= '0;
      id_q    <= '0;
      wdata_q <= '0;
      rwn_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (setup) begin
          addr_q  <= paddr[2 +: UDMA_CFG_REG_AW];
          id_q    <= paddr_id;
          wdata_q <= apb.pwdata;
          rwn_q   <= !apb.pwrite;
          rdata_q <= UDMA_CFG_ERR_DATA;
          err_q   <= !id_ok;
        end
        ST_REQ: if (ready_sel) begin
          rdata_q <= rwn_q ? lane_rdata : '0;
          err_q   <= 1'b0;
        end else if (wdt_expired) begin
          rdata_q <= UDMA_CFG_ERR_DATA;
          err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_data_o = wdata_q;
  assign cfg_addr_o = addr_q;
  assign cfg_rwn_o  = rwn_q;

  // outputs decoded from state so a reset drops cfg_valid immediately
  always_comb begin
    cfg_valid_o = '0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    case (state_q)
      ST_REQ: begin
        for (int k = 0; k < N_PERIPHS; k++)
          if (id_q == PER_ID_W'(k)) cfg_valid_o[k] = 1'b1;
      end
      ST_RESP: begin
        apb.pready  = 1'b1;
        apb.prdata  = rdata_q;
        apb.pslverr = err_q;
      end
      default: ;
    endcase
  end
endmodule
